// File: rtl/psum_pass_scheduler.sv
// psum_pass_scheduler
//   Sequences the partial-sum accumulation memory across a layer. Each
//   (output tile, input tile) pair gets one accumulate pass:
//   START -> REQ (work order) -> WAIT_VALID (count batch+1 valids) -> DRAIN.
//   The drain wait lets the memory's add/write pipeline retire before the next
//   pass reads the same addresses. Host readback is gated off while busy.
//
// Optional build macro: PSUM_SCHED_STATS_EN adds stat_busy_cycles and
//   stat_stall_cycles, two saturating 32-bit counters.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   go                  launch pulse, honoured only when idle
//   cfg_base/batch/out_tiles/in_tiles   layer configuration, latched on go
//   busy, done          layer in progress / one-cycle completion pulse
//   err_extra_valid     sticky: valid arrived when no pass was collecting
//   ps_start, ps_accumulate, ps_address_start, ps_batch   memory controls
//   ps_valid_in         partial-sum valid from the engine
//   tile_valid/ready, tile_out_idx, tile_in_idx            engine work order
//   host_s_en_in/host_s_en   host read enable, forced low while busy

module psum_pass_scheduler #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned BATCH_W      = 6,
  parameter int unsigned TILE_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [BATCH_W-1:0] cfg_batch,
  input  logic [TILE_W-1:0]  cfg_out_tiles,
  input  logic [TILE_W-1:0]  cfg_in_tiles,
  output logic               busy,
  output logic               done,
  output logic               err_extra_valid,
  output logic               ps_start,
  output logic               ps_accumulate,
  output logic [ADDR_W-1:0]  ps_address_start,
  output logic [BATCH_W-1:0] ps_batch,
  input  logic               ps_valid_in,
  output logic               tile_valid,
  input  logic               tile_ready,
  output logic [TILE_W-1:0]  tile_out_idx,
  output logic [TILE_W-1:0]  tile_in_idx,
  input  logic               host_s_en_in,
  output logic               host_s_en
`ifdef PSUM_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_busy_cycles,
  output logic [31:0]        stat_stall_cycles
`endif
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] REQ        = 3'd2;
  localparam logic [2:0] WAIT_VALID = 3'd3;
  localparam logic [2:0] DRAIN      = 3'd4;
  localparam logic [2:0] FINISH     = 3'd5;

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  logic [2:0]         state_q;
  logic [TILE_W-1:0]  out_tiles_q, in_tiles_q, o_q, i_q;
  logic [BATCH_W-1:0] batch_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               acc_q, err_q;
  logic [BATCH_W:0]   vcnt_q;
  logic [DrainW-1:0]  dcnt_q;

  logic               handshake, count_valid, collecting;
  logic [BATCH_W:0]   entries, vcnt_inc;
  logic [ADDR_W-1:0]  stride;
  logic [TILE_W:0]    i_next, o_next;

  always_comb begin
    handshake   = (state_q == REQ) && tile_ready;
    collecting  = (state_q == REQ) || (state_q == WAIT_VALID);
    // Valids count from the handshake cycle onward; earlier REQ cycles are ignored.
    count_valid = ps_valid_in && (handshake || (state_q == WAIT_VALID));
    entries     = {1'b0, batch_q} + 1'b1;
    vcnt_inc    = vcnt_q + {{BATCH_W{1'b0}}, count_valid};
    stride      = ADDR_W'(entries);
    i_next      = {1'b0, i_q} + 1'b1;
    o_next      = {1'b0, o_q} + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_tiles_q <= '0;
      in_tiles_q  <= '0;
      o_q         <= '0;
      i_q         <= '0;
      batch_q     <= '0;
      addr_q      <= '0;
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      vcnt_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      if (ps_valid_in && !collecting) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (go) begin
            out_tiles_q <= cfg_out_tiles;
            in_tiles_q  <= cfg_in_tiles;
            batch_q     <= cfg_batch;
            addr_q      <= cfg_base;
            acc_q       <= 1'b0;
            o_q         <= '0;
            i_q         <= '0;
            err_q       <= 1'b0;  // overrides a same-cycle stray valid
            state_q     <= (cfg_out_tiles == '0 || cfg_in_tiles == '0) ? FINISH : START;
          end
        end
        START: begin
          vcnt_q  <= '0;
          state_q <= REQ;
        end
        REQ: begin
          if (tile_ready) begin
            vcnt_q <= vcnt_inc;
            if (vcnt_inc == entries) begin
              dcnt_q  <= DrainW'(DRAIN_CYCLES);
              state_q <= DRAIN;
            end else begin
              state_q <= WAIT_VALID;
            end
          end
        end
        WAIT_VALID: begin
          vcnt_q <= vcnt_inc;
          if (vcnt_inc == entries) begin
            dcnt_q  <= DrainW'(DRAIN_CYCLES);
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Counter is 1 on the last drain cycle, so DRAIN lasts DRAIN_CYCLES cycles.
          if (dcnt_q <= DrainW'(1)) begin
            if (i_next < {1'b0, in_tiles_q}) begin
              i_q     <= i_next[TILE_W-1:0];
              acc_q   <= 1'b1;
              state_q <= START;
            end else if (o_next < {1'b0, out_tiles_q}) begin
              i_q     <= '0;
              o_q     <= o_next[TILE_W-1:0];
              acc_q   <= 1'b0;
              // Running sum of base + o*(batch+1); wraps mod 2^ADDR_W.
              addr_q  <= addr_q + stride;
              state_q <= START;
            end else begin
              i_q     <= '0;
              state_q <= FINISH;
            end
          end else begin
            dcnt_q <= dcnt_q - 1'b1;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (state_q != IDLE);
    done             = (state_q == FINISH);
    ps_start         = (state_q == START);
    tile_valid       = (state_q == REQ);
    err_extra_valid  = err_q;
    ps_accumulate    = acc_q;
    ps_address_start = addr_q;
    ps_batch         = batch_q;
    tile_out_idx     = o_q;
    tile_in_idx      = i_q;
    host_s_en        = host_s_en_in && !busy;
  end

`ifdef PSUM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || (state_q == IDLE && go)) begin
      stat_busy_cycles  <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (busy && !(&stat_busy_cycles)) begin
        stat_busy_cycles <= stat_busy_cycles + 32'd1;
      end
      if (state_q == REQ && !tile_ready && !(&stat_stall_cycles)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_psum_pass_scheduler.sv
// Self-checking bench for psum_pass_scheduler. A reference model expands each
// launched layer into its list of passes; a monitor checks every ps_start,
// work-order handshake and done pulse against that list.
module tb_psum_pass_scheduler;
  localparam int ADDR_W = 11;
  localparam int BATCH_W = 6;
  localparam int TILE_W = 8;
  localparam int DRAIN = 16;

  logic clk = 1'b0, reset, go;
  logic [ADDR_W-1:0] cfg_base;
  logic [BATCH_W-1:0] cfg_batch;
  logic [TILE_W-1:0] cfg_out_tiles, cfg_in_tiles;
  logic busy, done, err_extra_valid, ps_start, ps_accumulate;
  logic [ADDR_W-1:0] ps_address_start;
  logic [BATCH_W-1:0] ps_batch;
  logic ps_valid_in, tile_valid, tile_ready;
  logic [TILE_W-1:0] tile_out_idx, tile_in_idx;
  logic host_s_en_in, host_s_en;
`ifdef PSUM_SCHED_STATS_EN
  logic [31:0] stat_busy_cycles, stat_stall_cycles;
`endif

  psum_pass_scheduler dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_base(cfg_base), .cfg_batch(cfg_batch),
    .cfg_out_tiles(cfg_out_tiles), .cfg_in_tiles(cfg_in_tiles),
    .busy(busy), .done(done), .err_extra_valid(err_extra_valid),
    .ps_start(ps_start), .ps_accumulate(ps_accumulate),
    .ps_address_start(ps_address_start), .ps_batch(ps_batch),
    .ps_valid_in(ps_valid_in), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_out_idx(tile_out_idx), .tile_in_idx(tile_in_idx),
    .host_s_en_in(host_s_en_in), .host_s_en(host_s_en)
`ifdef PSUM_SCHED_STATS_EN
    , .stat_busy_cycles(stat_busy_cycles), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit acc; int o; int i; } pass_t;
  pass_t exp_q[$];
  pass_t cur;
  bit cur_valid = 0;
  int total = 0, bad = 0, cyc = 0;
  int go_cyc = 0, done_cyc = 0, last_valid_cyc = 0;
  int done_cnt = 0, start_cnt = 0, exp_starts = 0, m_batch = 0;
  int eng_stall = 0, eng_max = 1000;
  bit eng_gaps = 0, eng_extra = 0, eng_early = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every (o, i) pair in loop order; address from base + o*(batch+1) mod 2^ADDR_W.
  task automatic build_model(input int base, input int batch, input int outt, input int in_t);
    exp_q.delete();
    for (int o = 0; o < outt; o++)
      for (int i = 0; i < in_t; i++)
        exp_q.push_back('{(base + o * (batch + 1)) % (1 << ADDR_W), i != 0, o, i});
    exp_starts = outt * in_t;
    m_batch = batch;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (ps_start) begin
        start_cnt++;
        if (start_cnt == 1) begin
          check("first_start_latency", cyc - go_cyc, 1);
          check("err_cleared_on_go", err_extra_valid, 0);
        end
        check("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          cur_valid = 1;
          check("ps_batch", ps_batch, m_batch);
        end
      end
      if (cur_valid && busy) begin
        check("ps_address_start", ps_address_start, cur.addr);
        check("ps_accumulate", ps_accumulate, cur.acc);
      end
      if (busy && host_s_en_in) check("host_gated_busy", host_s_en, 0);
      if (tile_valid && tile_ready && cur_valid) begin
        check("tile_out_idx", tile_out_idx, cur.o);
        check("tile_in_idx", tile_in_idx, cur.i);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("passes_left_at_done", exp_q.size(), 0);
        check("start_count", start_cnt, exp_starts);
        if (exp_starts > 0) check("done_after_last_valid", cyc - last_valid_cyc, DRAIN + 1);
        else check("degenerate_done_latency", cyc - go_cyc, 1);
        cur_valid = 0;
      end
    end
  end

  // Compute-engine model: optional stall, handshake, then batch+1 valids.
  initial begin
    tile_ready = 0;
    ps_valid_in = 0;
    forever begin
      @(posedge clk); #1;
      if (tile_valid && !reset) begin
        automatic int k0 = 0;
        for (int s = 0; s < eng_stall; s++) begin
          check("stall_tile_valid_held", tile_valid, 1);
          if (cur_valid) check("stall_idx_held", tile_in_idx, cur.i);
          @(posedge clk); #1;
        end
        tile_ready = 1;
        if (eng_early) begin
          ps_valid_in = 1;
          last_valid_cyc = cyc;
          k0 = 1;
        end
        @(posedge clk); #1;
        tile_ready = 0;
        ps_valid_in = 0;
        for (int k = k0; k <= m_batch && k < eng_max; k++) begin
          if (eng_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          ps_valid_in = 1;
          last_valid_cyc = cyc;
          @(posedge clk); #1;
          ps_valid_in = 0;
        end
        if (eng_extra && eng_max > m_batch) begin
          repeat (3) begin @(posedge clk); #1; end
          ps_valid_in = 1;
          @(posedge clk); #1;
          ps_valid_in = 0;
        end
      end
    end
  end

  task automatic launch(input int base, input int batch, input int outt, input int in_t);
    cfg_base = ADDR_W'(base);
    cfg_batch = BATCH_W'(batch);
    cfg_out_tiles = TILE_W'(outt);
    cfg_in_tiles = TILE_W'(in_t);
    build_model(base, batch, outt, in_t);
    start_cnt = 0;
    cur_valid = 0;
    go = 1;
    go_cyc = cyc;
    @(posedge clk); #1;
    go = 0;
  endtask

  task automatic run(input int base, input int batch, input int outt, input int in_t,
                     input int stall, input bit gaps, input bit extra, input bit busy_go);
    int d0;
    eng_stall = stall;
    eng_gaps = gaps;
    eng_extra = extra;
    d0 = done_cnt;
    launch(base, batch, outt, in_t);
    if (busy_go) begin
      repeat (6) begin @(posedge clk); #1; end
      cfg_base = ADDR_W'($urandom);
      cfg_batch = BATCH_W'($urandom);
      cfg_out_tiles = 5;
      cfg_in_tiles = 5;
      go = 1;
      @(posedge clk); #1;
      go = 0;
    end
    for (int n = 0; n < 20000 && done_cnt == d0; n++) begin @(posedge clk); #1; end
    check("done_seen", done_cnt - d0, 1);
    check("busy_after_done", busy, 0);
    check("err_extra_valid", err_extra_valid, extra);
    check("host_follows_idle", host_s_en, host_s_en_in);
`ifdef PSUM_SCHED_STATS_EN
    check("stat_busy_cycles", stat_busy_cycles, done_cyc - go_cyc);
    check("stat_stall_cycles", stat_stall_cycles, stall * exp_starts);
`endif
    repeat (20) begin @(posedge clk); #1; end
    check("single_done", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    reset = 1; go = 0; host_s_en_in = 0;
    cfg_base = 0; cfg_batch = 0; cfg_out_tiles = 0; cfg_in_tiles = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", ps_start, 0);
    check("rst_tile_valid", tile_valid, 0);
    check("rst_addr", ps_address_start, 0);
    reset = 0;
    host_s_en_in = 1;
    @(negedge clk);
    check("host_idle_pass", host_s_en, 1);
    host_s_en_in = 0;
    @(posedge clk); #1;

    run(12'h100, 3, 1, 1, 0, 0, 0, 0);   // single pass, no stall
    run(0, 7, 2, 3, 0, 1, 0, 0);         // accumulation sweep
    run(12'h7F8, 15, 2, 1, 5, 0, 0, 0);  // address wrap with backpressure
    run(12'h055, 4, 3, 0, 0, 0, 0, 0);   // degenerate: no input tiles
    run(12'h055, 4, 0, 2, 0, 0, 0, 0);   // degenerate: no output tiles
    run(12'h020, 2, 2, 2, 1, 0, 0, 1);   // go while busy ignored
    host_s_en_in = 1;
    run(12'h300, 3, 1, 2, 0, 0, 1, 0);   // stray valid in DRAIN, host gated
    host_s_en_in = 0;
    for (int r = 0; r < 5; r++) begin
      eng_early = r[0];
      run($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 1, 0, 0);
    end
    eng_early = 0;

    // Reset in the second pass after 2 of 8 valids.
    eng_stall = 0; eng_gaps = 0; eng_extra = 0;
    d0 = done_cnt;
    launch(12'h010, 7, 1, 2);
    for (int n = 0; n < 500 && start_cnt < 2; n++) @(negedge clk);
    eng_max = 2;
    repeat (12) begin @(posedge clk); #1; end
    check("partial_pass_acc", ps_accumulate, 1);
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_acc", ps_accumulate, 0);
    check("mid_rst_in_idx", tile_in_idx, 0);
    check("mid_rst_addr", ps_address_start, 0);
    check("mid_rst_batch", ps_batch, 0);
    check("mid_rst_err", err_extra_valid, 0);
    reset = 0;
    exp_q.delete();
    cur_valid = 0;
    eng_max = 1000;
    @(posedge clk); #1;
    check("no_done_after_reset", done_cnt - d0, 0);
    run(12'h010, 2, 2, 2, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
